// File: rtl/cpu_pkg.sv
// Shared constants and the ID/EX register layout for the decode-to-execute stage.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned REG_IDX_W  = 3;
  localparam int unsigned OPC_W      = 5;
  localparam int unsigned FUNCT_W    = 2;

  localparam logic [OPC_W-1:0]      OPC_NOP      = 5'b00000;
  localparam logic [FUNCT_W-1:0]    BUBBLE_FUNCT = '0;
  localparam logic [REG_IDX_W-1:0]  BUBBLE_IDX   = '0;
  localparam logic [DATA_WIDTH-1:0] BUBBLE_DATA  = '0;

  // rs, rt and use_imm are kept only so held operands can be refreshed during a stall.
  typedef struct packed {
    logic                  valid;
    logic [OPC_W-1:0]      opcode;
    logic [FUNCT_W-1:0]    funct;
    logic [REG_IDX_W-1:0]  rd;
    logic                  reg_write;
    logic [DATA_WIDTH-1:0] ain;
    logic [DATA_WIDTH-1:0] bin;
    logic [REG_IDX_W-1:0]  rs;
    logic [REG_IDX_W-1:0]  rt;
    logic                  use_imm;
  } ex_state_t;

  localparam ex_state_t EX_BUBBLE = '{
    valid:     1'b0,
    opcode:    OPC_NOP,
    funct:     BUBBLE_FUNCT,
    rd:        BUBBLE_IDX,
    reg_write: 1'b0,
    ain:       BUBBLE_DATA,
    bin:       BUBBLE_DATA,
    rs:        BUBBLE_IDX,
    rt:        BUBBLE_IDX,
    use_imm:   1'b0
  };

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select: EX/MEM result, then MEM/WB result, then the default data.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [REG_IDX_W-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_exm_reg_write,
  input  logic [REG_IDX_W-1:0]  i_exm_rd,
  input  logic [DATA_WIDTH-1:0] i_exm_result,
  input  logic                  i_mwb_reg_write,
  input  logic [REG_IDX_W-1:0]  i_mwb_rd,
  input  logic [DATA_WIDTH-1:0] i_mwb_result,
  output logic [DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_exm_reg_write && (i_exm_rd == i_idx)) begin
      o_data = i_exm_result;
    end else if (i_mwb_reg_write && (i_mwb_rd == i_idx)) begin
      o_data = i_mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with forwarding at capture and refresh while stalled.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [OPC_W-1:0]      id_opcode,
  input  logic [FUNCT_W-1:0]    id_funct,
  input  logic [REG_IDX_W-1:0]  id_rs,
  input  logic [REG_IDX_W-1:0]  id_rt,
  input  logic [REG_IDX_W-1:0]  id_rd,
  input  logic [DATA_WIDTH-1:0] id_rs_data,
  input  logic [DATA_WIDTH-1:0] id_rt_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  id_use_imm,
  input  logic                  id_reg_write,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exm_reg_write,
  input  logic [REG_IDX_W-1:0]  exm_rd,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_IDX_W-1:0]  mwb_rd,
  input  logic [DATA_WIDTH-1:0] mwb_result,
  output logic                  ex_valid,
  output logic [OPC_W-1:0]      ex_opcode,
  output logic [FUNCT_W-1:0]    ex_funct,
  output logic [DATA_WIDTH-1:0] ex_ain,
  output logic [DATA_WIDTH-1:0] ex_bin,
  output logic [REG_IDX_W-1:0]  ex_rd,
  output logic                  ex_reg_write
);

  ex_state_t r_ex;
  ex_state_t w_next;

  logic [REG_IDX_W-1:0]  w_sel_rs;
  logic [REG_IDX_W-1:0]  w_sel_rt;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;
  logic [DATA_WIDTH-1:0] w_fwd_a;
  logic [DATA_WIDTH-1:0] w_fwd_b;

  // One forwarding unit per operand, shared between capture and stall refresh.
  assign w_sel_rs = stall ? r_ex.rs  : id_rs;
  assign w_sel_rt = stall ? r_ex.rt  : id_rt;
  assign w_sel_a  = stall ? r_ex.ain : id_rs_data;
  assign w_sel_b  = stall ? r_ex.bin : id_rt_data;

  fwd_sel u_fwd_a (
    .i_idx           (w_sel_rs),
    .i_data          (w_sel_a),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_data          (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_idx           (w_sel_rt),
    .i_data          (w_sel_b),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_data          (w_fwd_b)
  );

  always_comb begin
    w_next = r_ex;
    if (flush) begin
      w_next = EX_BUBBLE;
    end else if (stall) begin
      if (r_ex.valid) begin
        w_next.ain = w_fwd_a;
        if (!r_ex.use_imm) begin
          w_next.bin = w_fwd_b;
        end
      end
    end else if (!id_valid) begin
      w_next = EX_BUBBLE;
    end else begin
      w_next.valid     = 1'b1;
      w_next.opcode    = id_opcode;
      w_next.funct     = id_funct;
      w_next.rd        = id_rd;
      w_next.reg_write = id_reg_write;
      w_next.ain       = w_fwd_a;
      w_next.bin       = id_use_imm ? id_imm : w_fwd_b;
      w_next.rs        = id_rs;
      w_next.rt        = id_rt;
      w_next.use_imm   = id_use_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= EX_BUBBLE;
    end else begin
      r_ex <= w_next;
    end
  end

  assign ex_valid     = r_ex.valid;
  assign ex_opcode    = r_ex.opcode;
  assign ex_funct     = r_ex.funct;
  assign ex_ain       = r_ex.ain;
  assign ex_bin       = r_ex.bin;
  assign ex_rd        = r_ex.rd;
  assign ex_reg_write = r_ex.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [1:0]  id_funct;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic [2:0]  id_rd;
  logic [15:0] id_rs_data;
  logic [15:0] id_rt_data;
  logic [15:0] id_imm;
  logic        id_use_imm;
  logic        id_reg_write;
  logic        stall;
  logic        flush;
  logic        exm_reg_write;
  logic [2:0]  exm_rd;
  logic [15:0] exm_result;
  logic        mwb_reg_write;
  logic [2:0]  mwb_rd;
  logic [15:0] mwb_result;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [1:0]  ex_funct;
  logic [15:0] ex_ain;
  logic [15:0] ex_bin;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_funct      (id_funct),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_reg_write  (id_reg_write),
    .stall         (stall),
    .flush         (flush),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_funct      (ex_funct),
    .ex_ain        (ex_ain),
    .ex_bin        (ex_bin),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; id_valid = 0; id_opcode = 0; id_funct = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_use_imm = 0; id_reg_write = 0; stall = 0; flush = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", ex_valid); end
    n_tests++; if (ex_opcode !== 5'd0) begin n_fail++; $display("FAIL rst_opcode got %b want 00000", ex_opcode); end
    n_tests++; if (ex_ain !== 16'h0) begin n_fail++; $display("FAIL rst_ain got %h want 0000", ex_ain); end
    // Reset while a valid instruction is held by stall
    rst = 0; id_valid = 1; id_opcode = 5'b10011; id_funct = 2'b10; id_rs = 1; id_rs_data = 16'h0ABC;
    id_rt = 2; id_rt_data = 16'h0DEF; id_rd = 3; id_reg_write = 1;
    tick();
    stall = 1;
    tick();
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL held_valid got %0b want 1", ex_valid); end
    rst = 1;
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid got %0b want 0", ex_valid); end
    n_tests++; if (ex_opcode !== 5'd0) begin n_fail++; $display("FAIL rst_stall_opcode got %b want 00000", ex_opcode); end
    n_tests++; if (ex_funct !== 2'd0) begin n_fail++; $display("FAIL rst_stall_funct got %b want 00", ex_funct); end
    n_tests++; if (ex_ain !== 16'h0 || ex_bin !== 16'h0) begin n_fail++; $display("FAIL rst_stall_ops got %h/%h want 0000/0000", ex_ain, ex_bin); end
    n_tests++; if (ex_rd !== 3'd0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_stall_rd_rw got %0d/%0b want 0/0", ex_rd, ex_reg_write); end
    clear_inputs();
  endtask

  task automatic test_capture();
    clear_inputs();
    id_valid = 1; id_opcode = 5'b11011; id_funct = 2'b00; id_rs = 1; id_rs_data = 16'h0005;
    id_rt = 2; id_rt_data = 16'h0003; id_rd = 4; id_reg_write = 1;
    tick();
    n_tests++; if (ex_ain !== 16'h0005) begin n_fail++; $display("FAIL cap_ain got %h want 0005", ex_ain); end
    n_tests++; if (ex_bin !== 16'h0003) begin n_fail++; $display("FAIL cap_bin got %h want 0003", ex_bin); end
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid got %0b want 1", ex_valid); end
    n_tests++; if (ex_opcode !== 5'b11011) begin n_fail++; $display("FAIL cap_opcode got %b want 11011", ex_opcode); end
    n_tests++; if (ex_rd !== 3'd4 || ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL cap_rd_rw got %0d/%0b want 4/1", ex_rd, ex_reg_write); end
    clear_inputs();
  endtask

  task automatic test_dual_fwd();
    clear_inputs();
    id_valid = 1; id_opcode = 5'b00101; id_rs = 3; id_rs_data = 16'h0009;
    id_rt = 6; id_rt_data = 16'h0008;
    exm_reg_write = 1; exm_rd = 3; exm_result = 16'h1111;
    mwb_reg_write = 1; mwb_rd = 3; mwb_result = 16'h2222;
    tick();
    n_tests++; if (ex_ain !== 16'h1111) begin n_fail++; $display("FAIL dual_fwd_ain got %h want 1111", ex_ain); end
    n_tests++; if (ex_bin !== 16'h0008) begin n_fail++; $display("FAIL dual_fwd_bin got %h want 0008", ex_bin); end
    // MEM/WB alone forwards; a non-writing EX/MEM match is ignored
    exm_reg_write = 0; exm_rd = 6; mwb_rd = 6;
    tick();
    n_tests++; if (ex_bin !== 16'h2222) begin n_fail++; $display("FAIL mwb_fwd_bin got %h want 2222", ex_bin); end
    n_tests++; if (ex_ain !== 16'h0009) begin n_fail++; $display("FAIL nofwd_ain got %h want 0009", ex_ain); end
    clear_inputs();
  endtask

  task automatic test_imm_hold();
    clear_inputs();
    id_valid = 1; id_opcode = 5'b01000; id_use_imm = 1; id_imm = 16'h00FF;
    id_rt = 4; id_rt_data = 16'h1234; id_rs = 0; id_rs_data = 16'h0007;
    tick();
    n_tests++; if (ex_bin !== 16'h00FF) begin n_fail++; $display("FAIL imm_cap_bin got %h want 00FF", ex_bin); end
    stall = 1; mwb_reg_write = 1; mwb_rd = 4; mwb_result = 16'hAAAA;
    tick();
    n_tests++; if (ex_bin !== 16'h00FF) begin n_fail++; $display("FAIL imm_stall1_bin got %h want 00FF", ex_bin); end
    tick();
    n_tests++; if (ex_bin !== 16'h00FF) begin n_fail++; $display("FAIL imm_stall2_bin got %h want 00FF", ex_bin); end
    n_tests++; if (ex_ain !== 16'h0007) begin n_fail++; $display("FAIL imm_stall_ain got %h want 0007", ex_ain); end
    clear_inputs();
  endtask

  task automatic test_stall_refresh();
    clear_inputs();
    id_valid = 1; id_opcode = 5'b10101; id_funct = 2'b01; id_rs = 5; id_rs_data = 16'h0001;
    id_rt = 6; id_rt_data = 16'h0022; id_rd = 7; id_reg_write = 1;
    tick();
    n_tests++; if (ex_ain !== 16'h0001) begin n_fail++; $display("FAIL sr_cap_ain got %h want 0001", ex_ain); end
    stall = 1; id_opcode = 5'b11111; id_rs_data = 16'hFFFF;
    tick();
    n_tests++; if (ex_ain !== 16'h0001 || ex_opcode !== 5'b10101) begin n_fail++; $display("FAIL sr_hold got %h/%b want 0001/10101", ex_ain, ex_opcode); end
    mwb_reg_write = 1; mwb_rd = 5; mwb_result = 16'hBEEF;
    tick();
    n_tests++; if (ex_ain !== 16'hBEEF) begin n_fail++; $display("FAIL sr_ain got %h want BEEF", ex_ain); end
    n_tests++; if (ex_bin !== 16'h0022) begin n_fail++; $display("FAIL sr_bin got %h want 0022", ex_bin); end
    n_tests++; if (ex_funct !== 2'b01 || ex_rd !== 3'd7 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL sr_fields got %b/%0d/%0b want 01/7/1", ex_funct, ex_rd, ex_valid); end
    mwb_reg_write = 0; exm_reg_write = 1; exm_rd = 6; exm_result = 16'h3333;
    tick();
    n_tests++; if (ex_bin !== 16'h3333 || ex_ain !== 16'hBEEF) begin n_fail++; $display("FAIL sr_exm got %h/%h want BEEF/3333", ex_ain, ex_bin); end
    clear_inputs();
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    id_valid = 1; id_opcode = 5'b00111; id_rs = 2; id_rs_data = 16'h4321; id_rd = 5; id_reg_write = 1;
    tick();
    flush = 1; stall = 1;
    tick();
    n_tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL fl_valid_rw got %0b/%0b want 0/0", ex_valid, ex_reg_write); end
    n_tests++; if (ex_opcode !== 5'd0 || ex_ain !== 16'h0 || ex_rd !== 3'd0) begin n_fail++; $display("FAIL fl_fields got %b/%h/%0d want 00000/0000/0", ex_opcode, ex_ain, ex_rd); end
    flush = 0; stall = 0; id_valid = 0;
    tick();
    n_tests++; if (ex_valid !== 1'b0 || ex_opcode !== 5'd0 || ex_ain !== 16'h0) begin n_fail++; $display("FAIL fl_idle got %0b/%b/%h want 0/00000/0000", ex_valid, ex_opcode, ex_ain); end
    // A stalled bubble must not pick up forwarded data
    stall = 1; mwb_reg_write = 1; mwb_rd = 0; mwb_result = 16'h5555;
    tick();
    n_tests++; if (ex_ain !== 16'h0 || ex_bin !== 16'h0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_stall got %h/%h/%0b want 0000/0000/0", ex_ain, ex_bin, ex_valid); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    id_valid = 1; id_opcode = 5'b00001; id_funct = 2'b11; id_rs = 1; id_rs_data = 16'h1000;
    id_rt = 2; id_rt_data = 16'h2000; id_rd = 1; id_reg_write = 1;
    tick();
    n_tests++; if (ex_ain !== 16'h1000 || ex_bin !== 16'h2000) begin n_fail++; $display("FAIL b2b_first got %h/%h want 1000/2000", ex_ain, ex_bin); end
    id_opcode = 5'b00010; id_funct = 2'b00; id_rs = 7; id_rs_data = 16'h0070; id_rd = 2; id_reg_write = 0;
    exm_reg_write = 1; exm_rd = 2; exm_result = 16'h4444;
    tick();
    n_tests++; if (ex_ain !== 16'h0070 || ex_bin !== 16'h4444) begin n_fail++; $display("FAIL b2b_second got %h/%h want 0070/4444", ex_ain, ex_bin); end
    n_tests++; if (ex_opcode !== 5'b00010 || ex_reg_write !== 1'b0 || ex_rd !== 3'd2) begin n_fail++; $display("FAIL b2b_fields got %b/%0b/%0d want 00010/0/2", ex_opcode, ex_reg_write, ex_rd); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_dual_fwd();
    test_imm_hold();
    test_stall_refresh();
    test_flush_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage that directly feeds the 16-bit ALU (opcode, funct, Ain, Bin).
- Latches decoded instruction fields and operands every cycle.
- Applies operand forwarding from the EX/MEM and MEM/WB stages, both at capture and while held.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Outputs are registered and drive the ALU inputs unchanged.

Parameters:
DATA_WIDTH, 16, operand/result width
REG_IDX_W, 3, register index width (8 GPRs, r0 is a normal register)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a real instruction
id_opcode  in  5  Instr[15:11]
id_funct  in  2  Instr[1:0]
id_rs, id_rt, id_rd  in  3 each  source A, source B, destination indices
id_rs_data, id_rt_data  in  16 each  register-file read data
id_imm  in  16  extended immediate
id_use_imm  in  1  Bin takes immediate instead of rt
id_reg_write  in  1  instruction writes rd
stall  in  1  hold current contents
flush  in  1  replace contents with bubble
exm_reg_write, exm_rd, exm_result  in  1/3/16  EX/MEM writeback candidate
mwb_reg_write, mwb_rd, mwb_result  in  1/3/16  MEM/WB writeback candidate
ex_valid  out  1  EX holds a real instruction
ex_opcode  out  5  to ALU opcode
ex_funct  out  2  to ALU funct
ex_ain, ex_bin  out  16 each  to ALU Ain/Bin
ex_rd  out  3  destination index
ex_reg_write  out  1  qualified by ex_valid

Behaviour:
Reset:
- rst=1 at a rising edge clears all outputs to 0. ex_opcode=00000 is NOP, so the ALU outputs 0.
- Reset has priority over flush, stall and capture.
- Reset mid-stall discards the held instruction.

Per-edge priority is rst > flush > stall > capture.

Flush:
- Bubble: ex_valid=0, ex_opcode=00000, ex_funct=0, ex_reg_write=0, ex_rd=0, ex_ain=ex_bin=0.
- Flush overrides a simultaneous stall.

Capture (no stall/flush):
- id_valid=0 loads a bubble (same as flush).
- id_valid=1 loads the id_* fields.
- ex_reg_write=id_reg_write.
- ex_ain=fwd(id_rs, id_rs_data).
- ex_bin = id_use_imm ? id_imm : fwd(id_rt, id_rt_data).

fwd(idx, d) selection:
- exm_result if exm_reg_write && exm_rd==idx.
- else mwb_result if mwb_reg_write && mwb_rd==idx.
- else d.
- EX/MEM wins over MEM/WB when both match.

Stall (hold with refresh):
- All fields hold.
- ex_ain is replaced by fwd(held rs, ex_ain) each stalled cycle.
- ex_bin is replaced likewise only when the held use_imm=0.
- Refresh applies only if ex_valid=1; immediates are never overwritten.
- Held rs, rt and use_imm are internal state, not outputs.
- A stall of N cycles keeps one instruction for N+1 cycles total. Its operands reflect the newest matching writeback seen.

Latency:
- Exactly 1 cycle from ID inputs to ex_* outputs.
- Forwarding paths are combinational into the capture register only, never to outputs directly.

Other rules:
- No arithmetic is performed here; widths pass through unchanged.
- Load-use detection is not this block's job; the hazard unit must assert stall.

Decomposition:
Shared package (cpu_pkg):
- OPC_NOP = 5'b00000
- DATA_WIDTH, REG_IDX_W
- bubble field constants

Sub-module fwd_sel:
- Inputs: idx, default data, both writeback candidates.
- Output: selected 16-bit operand.
- Instantiated twice for capture and twice for refresh, or shared via a mux.

Test Plan:
1. Reset during a held stall with ex_valid=1 -> next cycle all outputs 0, ex_opcode=00000.
2. Plain capture: opcode 11011, funct 00, rs=1 data 0x0005, rt=2 data 0x0003, no forwarding -> next cycle ex_ain=0x0005, ex_bin=0x0003, ex_valid=1.
3. Dual forwarding match: rs=3, exm_rd=3 result 0x1111 and mwb_rd=3 result 0x2222 both writing -> ex_ain=0x1111.
4. Immediate not refreshed: use_imm=1 with imm=0x00FF, rt=4; stall two cycles with mwb_rd=4 result 0xAAAA -> ex_bin stays 0x00FF.
5. Stall refresh: rs=5 captured as 0x0001; stall, then mwb_rd=5 writes 0xBEEF -> next cycle ex_ain=0xBEEF, other fields unchanged.
6. Flush and stall asserted together -> bubble with ex_valid=0, ex_reg_write=0. A following id_valid=0 cycle keeps the bubble.
